// File: rtl/vga_sync_receiver.sv
// VGA sink: synchronizes hsync/vsync, recovers pixel coordinates and data enable,
// measures line/frame timing and declares lock against the configured video timing.
module vga_sync_receiver #(
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_TOTAL  = 525,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [23:0] rgb_in,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        de,
    output logic [23:0] rgb_out,
    output logic        frame_start,
    output logic        locked,
    output logic [11:0] line_len,
    output logic [10:0] frame_lines,
    output logic [7:0]  err_count
);

    // state      | meaning
    // ST_SEARCH  | waiting for the first vsync fall, no timing checks
    // ST_MEASURE | checking line lengths over one full frame
    // ST_LOCKED  | timing matches, data enable active
    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [12:0] H_TOTAL_L = 13'(H_TOTAL);
    localparam logic [11:0] V_TOTAL_L = 12'(V_TOTAL);
    localparam logic [11:0] TIMEOUT_L = 12'(2 * H_TOTAL);
    localparam logic [11:0] H_START_L = 12'(H_SYNC + H_BP);
    localparam logic [11:0] H_END_L   = 12'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] V_START_L = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_END_L   = 11'(V_SYNC + V_BP + V_ACTIVE);

    logic        hs_s1_q, hs_s2_q, hs_s3_q;
    logic        vs_s1_q, vs_s2_q, vs_s3_q;
    logic [23:0] rgb_p1_q, rgb_p2_q, rgb_p3_q;

    state_t      state_q, state_d;
    logic        bad_q, bad_d;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic [11:0] line_len_q, line_len_d;
    logic [10:0] frame_lines_q, frame_lines_d;
    logic [7:0]  err_q, err_d;

    logic [9:0]  pixel_x_q, pixel_y_q, pixel_x_d, pixel_y_d;
    logic        de_q, de_d, frame_start_q, frame_start_d, locked_q;
    logic [23:0] rgb_out_q;
    logic [11:0] line_len_o_q;
    logic [10:0] frame_lines_o_q;
    logic [7:0]  err_o_q;

    logic        hfall, vfall, checking, line_err, frame_err, timeout;
    logic [12:0] h_inc;
    logic [11:0] v_inc;
    logic        h_vis, v_vis;

    assign hfall    = hs_s3_q & ~hs_s2_q;
    assign vfall    = vs_s3_q & ~vs_s2_q;
    assign h_inc    = {1'b0, h_cnt_q} + 13'd1;
    assign v_inc    = {1'b0, v_cnt_q} + 12'd1;
    assign checking = (state_q != ST_SEARCH);

    always_comb begin
        h_cnt_d       = hfall ? 12'd0 : ((h_cnt_q == 12'hFFF) ? h_cnt_q : h_inc[11:0]);
        v_cnt_d       = v_cnt_q;
        if (vfall) begin
            v_cnt_d = 11'd0;
        end else if (hfall && v_cnt_q != 11'h7FF) begin
            v_cnt_d = v_inc[10:0];
        end
        line_len_d    = hfall ? h_inc[11:0] : line_len_q;
        frame_lines_d = vfall ? v_inc[10:0] : frame_lines_q;

        line_err  = hfall && checking && (h_inc != H_TOTAL_L);
        frame_err = vfall && (state_q == ST_LOCKED) && (v_inc != V_TOTAL_L);
        // h_cnt saturates, so this compare can only match once per stall
        timeout   = checking && (h_cnt_d == TIMEOUT_L);

        err_d = err_q;
        if ((line_err || frame_err || timeout) && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end

        state_d = state_q;
        bad_d   = bad_q;
        case (state_q)
            ST_SEARCH: begin
                if (vfall) begin
                    state_d = ST_MEASURE;
                    bad_d   = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (timeout) begin
                    state_d = ST_SEARCH;
                    bad_d   = 1'b0;
                end else begin
                    if (line_err) bad_d = 1'b1;
                    if (vfall) begin
                        if (!(bad_q || line_err) && v_inc == V_TOTAL_L) state_d = ST_LOCKED;
                        bad_d = 1'b0;
                    end
                end
            end
            ST_LOCKED: begin
                if (timeout) begin
                    state_d = ST_SEARCH;
                end else if (line_err || frame_err) begin
                    state_d = ST_MEASURE;
                end
                bad_d = 1'b0;
            end
            default: begin
                state_d = ST_SEARCH;
                bad_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        h_vis         = (h_cnt_q >= H_START_L) && (h_cnt_q < H_END_L);
        v_vis         = (v_cnt_q >= V_START_L) && (v_cnt_q < V_END_L);
        de_d          = (state_q == ST_LOCKED) && h_vis && v_vis;
        pixel_x_d     = de_d ? 10'(h_cnt_q - H_START_L) : 10'd0;
        pixel_y_d     = de_d ? 10'(v_cnt_q - V_START_L) : 10'd0;
        frame_start_d = de_d && (pixel_x_d == 10'd0) && (pixel_y_d == 10'd0);
    end

    // Sync registers reset high so reset release never looks like a sync fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_s1_q       <= 1'b1;
            hs_s2_q       <= 1'b1;
            hs_s3_q       <= 1'b1;
            vs_s1_q       <= 1'b1;
            vs_s2_q       <= 1'b1;
            vs_s3_q       <= 1'b1;
            state_q       <= ST_SEARCH;
            bad_q         <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            err_q         <= '0;
        end else begin
            hs_s1_q       <= hsync_in;
            hs_s2_q       <= hs_s1_q;
            hs_s3_q       <= hs_s2_q;
            vs_s1_q       <= vsync_in;
            vs_s2_q       <= vs_s1_q;
            vs_s3_q       <= vs_s2_q;
            state_q       <= state_d;
            bad_q         <= bad_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            err_q         <= err_d;
        end
    end

    // rgb travels four ranks to stay aligned with the sync -> count -> output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_p1_q        <= '0;
            rgb_p2_q        <= '0;
            rgb_p3_q        <= '0;
            rgb_out_q       <= '0;
            pixel_x_q       <= '0;
            pixel_y_q       <= '0;
            de_q            <= 1'b0;
            frame_start_q   <= 1'b0;
            locked_q        <= 1'b0;
            line_len_o_q    <= '0;
            frame_lines_o_q <= '0;
            err_o_q         <= '0;
        end else begin
            rgb_p1_q        <= rgb_in;
            rgb_p2_q        <= rgb_p1_q;
            rgb_p3_q        <= rgb_p2_q;
            rgb_out_q       <= rgb_p3_q;
            pixel_x_q       <= pixel_x_d;
            pixel_y_q       <= pixel_y_d;
            de_q            <= de_d;
            frame_start_q   <= frame_start_d;
            locked_q        <= (state_q == ST_LOCKED);
            line_len_o_q    <= line_len_q;
            frame_lines_o_q <= frame_lines_q;
            err_o_q         <= err_q;
        end
    end

    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign de          = de_q;
    assign rgb_out     = rgb_out_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign line_len    = line_len_o_q;
    assign frame_lines = frame_lines_o_q;
    assign err_count   = err_o_q;

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Sink end of the VGA link: consumes hsync/vsync/RGB as produced by the team's vga_controller/top pair.
- Recovers pixel coordinates and data-enable, measures line and frame timing, and declares lock against the 640x480@60 timing parameters.
- Used as the capture front-end for loopback verification of the display path and for future frame-grab blocks.
- Same clk_25MHZ domain as the generator; sync inputs are still double-registered.

Parameters:
H_TOTAL, 800, pixel clocks per line
H_SYNC, 96, hsync low width (clocks)
H_BP, 48, back porch after hsync (clocks)
H_ACTIVE, 640, visible pixels per line
V_TOTAL, 525, lines per frame
V_SYNC, 2, vsync low width (lines)
V_BP, 33, back porch after vsync (lines)
V_ACTIVE, 480, visible lines per frame

Ports:
clk  in  1  pixel clock (25 MHz)
rst_n  in  1  asynchronous active-low reset
hsync_in  in  1  horizontal sync, active-low
vsync_in  in  1  vertical sync, active-low
rgb_in  in  24  {R,G,B} 8 bits each
pixel_x  out  10  active-area column, 0..639
pixel_y  out  10  active-area row, 0..479
de  out  1  data enable, high for visible pixels only while locked
rgb_out  out  24  rgb_in aligned to pixel_x/pixel_y/de
frame_start  out  1  one-clock pulse when pixel (0,0) is presented
locked  out  1  timing matches parameters
line_len  out  12  last measured line length (clocks)
frame_lines  out  11  last measured lines per frame
err_count  out  8  saturating count of timing errors

Behaviour:
- Reset, async on rst_n low: all outputs 0, state SEARCH, all counters and pipeline registers 0.
- Sync registers reset to 1, so no edge is detected on release.
- Latency is fixed at 3 clk from input pins to every output, including rgb_out. A sample present at the pins on edge t appears on outputs after edge t+3.
- Edge detection uses synchronized signals only. Hfall = hsync 1->0. Vfall = vsync 1->0.
- h_cnt, 12 bit: 0 on Hfall, else +1, saturating at 4095. A sync-fall sample therefore has h_cnt=0.
- v_cnt, 11 bit: 0 on Vfall regardless of Hfall; else +1 on Hfall, saturating at 2047.
- Hfall and Vfall on the same clock: both counters cleared; vsync wins v_cnt.
- On Hfall: line_len <= h_cnt+1 (the previous line's length).
- On Vfall: frame_lines <= v_cnt+1.
- Line error: Hfall in MEASURE or LOCKED with h_cnt+1 != H_TOTAL.
- Frame error: Vfall in LOCKED with v_cnt+1 != V_TOTAL.
- Timeout: h_cnt reaches exactly 2*H_TOTAL in MEASURE or LOCKED. Fires once per stall because of saturation.
- err_count increments by 1 per error or timeout event, saturating at 255. Multiple events on one clock count as 1. err_count is cleared only by reset.
- FSM:
  - SEARCH: on Vfall -> MEASURE, with no checks in SEARCH.
  - MEASURE: a line error sets a sticky bad flag. On Vfall: if bad=0 and v_cnt+1==V_TOTAL -> LOCKED; otherwise clear bad and stay in MEASURE. Timeout -> SEARCH.
  - LOCKED: a line error or frame error -> MEASURE with bad cleared. Timeout -> SEARCH.
- locked is high exactly while state==LOCKED, registered. It rises one clock after the qualifying Vfall is processed.
- de = locked && H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE && V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACTIVE.
- pixel_x = h_cnt-(H_SYNC+H_BP) and pixel_y = v_cnt-(V_SYNC+V_BP) when de=1; both 0 when de=0.
- frame_start = de && pixel_x==0 && pixel_y==0.
- rgb_out is passed through unchanged, independent of de.

Test Plan:
- Reset: drive rst_n=0 mid-stream -> all outputs 0 asynchronously. Release, then one frame from vga_controller -> locked still 0 (still in MEASURE).
- Nominal 640x480 from top: locked rises 1 clk after the second Vfall (~420000 clks after the first). line_len=800, frame_lines=525, err_count=0.
- Alignment: top's grid (H 352..360, V 35..514 white) -> rgb_out=24'hFFFFFF with de=1 at pixel_x 208..216 for pixel_y 0. rgb_out=0 at (207,0). frame_start pulses once per frame at (0,0).
- Short line: one line of 799 clocks while locked -> err_count=1, locked=0 and remains 0 until the next clean full frame.
- Timeout: hold hsync_in=1 for 2000 clks while locked -> err_count+1 exactly once, state SEARCH, de=0. Relock after 2 clean Vfalls.
- Saturation: inject 300 bad lines -> err_count holds 255.
